// File: rtl/mem_arb_pkg.sv
// Shared types for the cacheline memory arbiter: arbitration mode, FSM states
// and the grant-pointer width helper.
package mem_arb_pkg;

   typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational requester picker: lowest index in fixed mode, first requester
// at or after rr_ptr (wrapping) in round-robin mode.
module rr_priority_picker
   import mem_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int PTR_W = ptr_width(N)
)
(
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] rr_ptr,
   input  arb_mode_e        mode,
   output logic             valid,
   output logic [N-1:0]     grant_oh,
   output logic [PTR_W-1:0] grant_idx
);

   logic [PTR_W-1:0] start;
   int               cand;

   always_comb begin
      valid     = 1'b0;
      grant_idx = '0;
      cand      = 0;
      start     = (mode == ARB_RR) ? rr_ptr : '0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(start) + k) % N;
         if (!valid && req[PTR_W'(cand)]) begin
            valid     = 1'b1;
            grant_idx = PTR_W'(cand);
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_oh
      assign grant_oh[gi] = valid && (grant_idx == PTR_W'(gi));
   end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel cacheline arbiter in front of the single cacheline adaptor: one
// transaction in flight, all downstream controls registered, line returned to its owner.
module mem_arbiter_n
   import mem_arb_pkg::*;
#(
   parameter int        NUM_CH   = 2,
   parameter int        s_offset = 5,
   parameter arb_mode_e ARB_MODE = ARB_RR,
   localparam int       LINE     = (2**s_offset) * 8,
   localparam int       PTR_W    = ptr_width(NUM_CH)
)
(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_CH-1:0]          ch_read_i,
   input  logic [NUM_CH-1:0]          ch_write_i,
   input  logic [NUM_CH-1:0][31:0]    ch_address_i,
   input  logic [NUM_CH-1:0][LINE-1:0] ch_line_i,
   output logic [NUM_CH-1:0]          ch_resp_o,
   output logic [LINE-1:0]            ch_line_o,
   output logic [31:0]                mem_address_o,
   output logic                       mem_read_o,
   output logic                       mem_write_o,
   output logic [LINE-1:0]            mem_line_o,
   input  logic [LINE-1:0]            mem_line_i,
   input  logic                       mem_resp_i,
   output logic                       err_o
);

   arb_state_e          state_reg;
   logic [PTR_W-1:0]    rr_ptr_reg;
   logic [PTR_W-1:0]    rr_ptr_next;
   logic [NUM_CH-1:0]   grant_oh_reg;
   logic [NUM_CH-1:0]   req;
   logic                pick_valid;
   logic [NUM_CH-1:0]   pick_oh;
   logic [PTR_W-1:0]    pick_idx;

   assign req         = ch_read_i | ch_write_i;
   assign rr_ptr_next = (pick_idx == PTR_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;

   rr_priority_picker #(.N(NUM_CH), .PTR_W(PTR_W)) u_picker (
      .req       (req),
      .rr_ptr    (rr_ptr_reg),
      .mode      (ARB_MODE),
      .valid     (pick_valid),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         grant_oh_reg  <= '0;
         ch_resp_o     <= '0;
         ch_line_o     <= '0;
         mem_address_o <= '0;
         mem_read_o    <= 1'b0;
         mem_write_o   <= 1'b0;
         mem_line_o    <= '0;
         err_o         <= 1'b0;
      end else begin
         // an adaptor response is only legal while a transaction is outstanding
         if (mem_resp_i && (state_reg != BUSY))
            err_o <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  grant_oh_reg  <= pick_oh;
                  mem_address_o <= ch_address_i[pick_idx];
                  mem_line_o    <= ch_line_i[pick_idx];
                  // read+write together resolves to a write and is flagged
                  mem_write_o   <= ch_write_i[pick_idx];
                  mem_read_o    <= ~ch_write_i[pick_idx];
                  if (ch_read_i[pick_idx] && ch_write_i[pick_idx])
                     err_o <= 1'b1;
                  if (ARB_MODE == ARB_RR)
                     rr_ptr_reg <= rr_ptr_next;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               if (mem_resp_i) begin
                  mem_read_o  <= 1'b0;
                  mem_write_o <= 1'b0;
                  if (!mem_write_o)
                     ch_line_o <= mem_line_i;
                  ch_resp_o <= grant_oh_reg;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               ch_resp_o <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n: a round-robin 4-channel instance for most
// scenarios and a fixed-priority 4-channel instance for the starvation case.
module tb_mem_arbiter_n;
   import mem_arb_pkg::*;

   localparam int N = 4;
   localparam int L = 256;

   typedef struct {
      logic [N-1:0] resp;
      logic         wr;
      logic [31:0]  addr;
      logic [L-1:0] wline;
      logic [L-1:0] rline;
   } exp_t;

   logic clk;
   int   checks   = 0;
   int   failures = 0;

   // round-robin instance
   logic                 reset_n;
   logic [N-1:0]         rr_read, rr_write, rr_ch_resp;
   logic [N-1:0][31:0]   rr_addr;
   logic [N-1:0][L-1:0]  rr_wline;
   logic [L-1:0]         rr_ch_line, rr_mem_line, rr_mem_line_in;
   logic [31:0]          rr_mem_addr;
   logic                 rr_mem_read, rr_mem_write, rr_mem_resp, rr_err;

   // fixed-priority instance
   logic                 fx_reset_n;
   logic [N-1:0]         fx_read, fx_write, fx_ch_resp;
   logic [N-1:0][31:0]   fx_addr;
   logic [N-1:0][L-1:0]  fx_wline;
   logic [L-1:0]         fx_ch_line, fx_mem_line, fx_mem_line_in;
   logic [31:0]          fx_mem_addr;
   logic                 fx_mem_read, fx_mem_write, fx_mem_resp, fx_err;

   exp_t rr_q[$];
   exp_t fx_q[$];
   logic auto_en;
   int   spur_cnt  = 0;
   int   spur_done = 0;

   mem_arbiter_n #(.NUM_CH(N), .s_offset(5), .ARB_MODE(ARB_RR)) u_rr (
      .clk(clk), .reset_n(reset_n),
      .ch_read_i(rr_read), .ch_write_i(rr_write),
      .ch_address_i(rr_addr), .ch_line_i(rr_wline),
      .ch_resp_o(rr_ch_resp), .ch_line_o(rr_ch_line),
      .mem_address_o(rr_mem_addr), .mem_read_o(rr_mem_read),
      .mem_write_o(rr_mem_write), .mem_line_o(rr_mem_line),
      .mem_line_i(rr_mem_line_in), .mem_resp_i(rr_mem_resp),
      .err_o(rr_err)
   );

   mem_arbiter_n #(.NUM_CH(N), .s_offset(5), .ARB_MODE(ARB_FIXED)) u_fx (
      .clk(clk), .reset_n(fx_reset_n),
      .ch_read_i(fx_read), .ch_write_i(fx_write),
      .ch_address_i(fx_addr), .ch_line_i(fx_wline),
      .ch_resp_o(fx_ch_resp), .ch_line_o(fx_ch_line),
      .mem_address_o(fx_mem_addr), .mem_read_o(fx_mem_read),
      .mem_write_o(fx_mem_write), .mem_line_o(fx_mem_line),
      .mem_line_i(fx_mem_line_in), .mem_resp_i(fx_mem_resp),
      .err_o(fx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // round-robin adaptor model: answers 3 cycles after issue, or sends a stray pulse on demand
   initial begin
      rr_mem_resp    = 1'b0;
      rr_mem_line_in = '0;
      forever begin
         @(negedge clk);
         if (spur_cnt != spur_done) begin
            rr_mem_resp    = 1'b1;
            rr_mem_line_in = {8{32'h5A5A_5A5A}};
            @(negedge clk);
            rr_mem_resp = 1'b0;
            spur_done++;
         end else if (auto_en && (rr_mem_read || rr_mem_write)) begin
            for (int c = 0; c < 3; c++) begin
               if (c > 0) @(negedge clk);
               if (rr_q.size() == 0) begin
                  chk("rr_unexpected_issue", {rr_mem_read, rr_mem_write}, '0);
               end else begin
                  chk("rr_mem_addr", rr_mem_addr, rr_q[0].addr);
                  chk("rr_mem_write", rr_mem_write, rr_q[0].wr);
                  chk("rr_mem_read", rr_mem_read, !rr_q[0].wr);
                  if (rr_q[0].wr) chk("rr_mem_line", rr_mem_line, rr_q[0].wline);
               end
            end
            rr_mem_resp    = 1'b1;
            rr_mem_line_in = rr_mem_write ? '1 : {8{rr_mem_addr}};
            @(negedge clk);
            rr_mem_resp = 1'b0;
         end
      end
   end

   // fixed-priority adaptor model
   initial begin
      fx_mem_resp    = 1'b0;
      fx_mem_line_in = '0;
      forever begin
         @(negedge clk);
         if (fx_mem_read || fx_mem_write) begin
            repeat (2) @(negedge clk);
            fx_mem_resp    = 1'b1;
            fx_mem_line_in = {8{fx_mem_addr}};
            @(negedge clk);
            fx_mem_resp = 1'b0;
         end
      end
   end

   // response monitors
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rr_ch_resp != '0) begin
            if (rr_q.size() == 0) begin
               chk("rr_unexpected_resp", rr_ch_resp, '0);
            end else begin
               e = rr_q.pop_front();
               $display("rr resp=%b line[31:0]=%h", rr_ch_resp, rr_ch_line[31:0]);
               chk("rr_resp", rr_ch_resp, e.resp);
               chk("rr_line", rr_ch_line, e.rline);
            end
         end
         if (fx_ch_resp != '0) begin
            if (fx_q.size() == 0) begin
               chk("fx_unexpected_resp", fx_ch_resp, '0);
            end else begin
               e = fx_q.pop_front();
               $display("fx resp=%b line[31:0]=%h", fx_ch_resp, fx_ch_line[31:0]);
               chk("fx_resp", fx_ch_resp, e.resp);
               chk("fx_line", fx_ch_line, e.rline);
            end
         end
      end
   end

   task automatic wait_rr_resps(input int n);
      int seen = 0;
      int cyc  = 0;
      while (seen < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (rr_ch_resp != '0) seen++;
      end
      rr_read  = '0;
      rr_write = '0;
      chk("rr_resp_count", seen, n);
   endtask

   task automatic rr_reset_outputs_zero(input string tag);
      chk({tag, "_mem_read"}, rr_mem_read, 1'b0);
      chk({tag, "_mem_write"}, rr_mem_write, 1'b0);
      chk({tag, "_ch_resp"}, rr_ch_resp, '0);
      chk({tag, "_ch_line"}, rr_ch_line, '0);
   endtask

   initial begin
      int   order[5] = '{0, 1, 2, 3, 0};
      int   seen;
      int   cyc;
      logic [N-1:0] oh;

      reset_n    = 1'b0;
      fx_reset_n = 1'b0;
      auto_en    = 1'b1;
      rr_read    = 4'b1111;
      rr_write   = '0;
      fx_read    = '0;
      fx_write   = '0;
      for (int i = 0; i < N; i++) begin
         rr_addr[i]  = 32'h0000_0040 + 32'(i) * 32'h100;
         rr_wline[i] = {8{32'hC0DE_0000 + 32'(i)}};
         fx_addr[i]  = 32'h0002_0000 + 32'(i) * 32'h20;
         fx_wline[i] = '0;
      end

      // reset held with every channel requesting
      repeat (3) @(negedge clk);
      rr_reset_outputs_zero("t1_reset");
      chk("t1_reset_addr", rr_mem_addr, '0);
      chk("t1_reset_err", rr_err, 1'b0);

      // round-robin order 0,1,2,3,0 from pointer 0
      for (int i = 0; i < 5; i++) begin
         oh = 4'b0001 << order[i];
         rr_q.push_back('{resp: oh, wr: 1'b0, addr: rr_addr[order[i]],
                          wline: '0, rline: {8{rr_addr[order[i]]}}});
      end
      reset_n = 1'b1;
      wait_rr_resps(5);

      // ch3 write; returned line must not disturb ch_line_o
      rr_addr[3]  = 32'h0000_1000;
      rr_wline[3] = {32{8'hA5}};
      rr_q.push_back('{resp: 4'b1000, wr: 1'b1, addr: 32'h0000_1000,
                       wline: {32{8'hA5}}, rline: {8{rr_addr[0]}}});
      rr_write = 4'b1000;
      wait_rr_resps(1);
      chk("t4_err_clean", rr_err, 1'b0);

      // reset in the middle of a read, then a late adaptor response
      auto_en = 1'b0;
      rr_read = 4'b0100;
      cyc = 0;
      while (!rr_mem_read && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("t5_busy_read", rr_mem_read, 1'b1);
      rr_read = '0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      rr_reset_outputs_zero("t5_mid_reset");
      chk("t5_err_in_reset", rr_err, 1'b0);
      reset_n = 1'b1;
      spur_cnt++;
      cyc = 0;
      while (spur_done != spur_cnt && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk("t5_err_late_resp", rr_err, 1'b1);
      rr_reset_outputs_zero("t5_after");

      // stray response in IDLE
      reset_n = 1'b0;
      @(negedge clk);
      chk("t6_err_cleared", rr_err, 1'b0);
      reset_n = 1'b1;
      spur_cnt++;
      cyc = 0;
      while (spur_done != spur_cnt && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk("t6_err_spurious", rr_err, 1'b1);

      // read+write together on ch0 goes out as a write and flags an error
      reset_n = 1'b0;
      @(negedge clk);
      chk("t6b_err_cleared", rr_err, 1'b0);
      reset_n = 1'b1;
      auto_en = 1'b1;
      rr_wline[0] = {8{32'hDEAD_0000}};
      rr_q.push_back('{resp: 4'b0001, wr: 1'b1, addr: rr_addr[0],
                       wline: {8{32'hDEAD_0000}}, rline: '0});
      rr_read  = 4'b0001;
      rr_write = 4'b0001;
      wait_rr_resps(1);
      chk("t6b_err_rw", rr_err, 1'b1);

      // fixed priority: ch1 beats ch2 every time
      for (int i = 0; i < 4; i++)
         fx_q.push_back('{resp: 4'b0010, wr: 1'b0, addr: fx_addr[1],
                          wline: '0, rline: {8{fx_addr[1]}}});
      fx_reset_n = 1'b1;
      fx_read    = 4'b0110;
      seen = 0;
      cyc  = 0;
      while (seen < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (fx_ch_resp != '0) seen++;
      end
      fx_read = '0;
      chk("fx_resp_count", seen, 4);
      repeat (4) @(negedge clk);
      chk("fx_err", fx_err, 1'b0);
      chk("fx_mem_write", fx_mem_write, 1'b0);
      chk("fx_mem_line_idle", fx_mem_line, '0);

      chk("rr_q_drained", rr_q.size(), 0);
      chk("fx_q_drained", fx_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
